mem_arbiter_3p: RTL



---
 rtl/mem_arbiter_3p.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter_3p.sv
// mem_arbiter_3p
//   Three-port arbiter and access sequencer for a shared single-port
//   32-bit x 64Ki-word memory (asynchronous read, write on falling edge).
//   Port 0 = loader/debug (absolute priority), port 1 = CPU data,
//   port 2 = CPU instruction fetch (ports 1/2 round-robin on ties).
//   One request accepted per cycle, executed the next cycle through a
//   registered address/write stage, read data returned one cycle later.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   pN_req/we/addr/wdata      port N request fields, held until granted
//   pN_gnt                    combinational accept (transfer on req & gnt)
//   pN_rvalid                 registered, rdata holds port N's read result
//   rdata                     registered read data shared by all ports
//   mem_address/data_in/write registered memory drive
//   mem_data_out              asynchronous memory read data
module mem_arbiter_3p #(
  parameter int unsigned BITS_DATA = 32,
  parameter int unsigned BITS_ADDR = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,

  input  logic                 p0_req,
  input  logic                 p0_we,
  input  logic [BITS_ADDR-1:0] p0_addr,
  input  logic [BITS_DATA-1:0] p0_wdata,
  output logic                 p0_gnt,
  output logic                 p0_rvalid,

  input  logic                 p1_req,
  input  logic                 p1_we,
  input  logic [BITS_ADDR-1:0] p1_addr,
  input  logic [BITS_DATA-1:0] p1_wdata,
  output logic                 p1_gnt,
  output logic                 p1_rvalid,

  input  logic                 p2_req,
  input  logic                 p2_we,
  input  logic [BITS_ADDR-1:0] p2_addr,
  input  logic [BITS_DATA-1:0] p2_wdata,
  output logic                 p2_gnt,
  output logic                 p2_rvalid,

  output logic [BITS_DATA-1:0] rdata,

  output logic [BITS_ADDR-1:0] mem_address,
  output logic [BITS_DATA-1:0] mem_data_in,
  output logic                 mem_write,
  input  logic [BITS_DATA-1:0] mem_data_out
);

  typedef enum logic [1:0] {
    PORT0 = 2'd0,
    PORT1 = 2'd1,
    PORT2 = 2'd2
  } port_e;

  // Arbitration results
  port_e                win;
  logic                 accept;
  logic                 win_we;
  logic [BITS_ADDR-1:0] win_addr;
  logic [BITS_DATA-1:0] win_wdata;

  // State
  port_e                rr_last_q,   rr_last_d;
  logic                 ex_valid_q,  ex_valid_d;
  port_e                ex_port_q,   ex_port_d;
  logic [BITS_ADDR-1:0] mem_addr_q,  mem_addr_d;
  logic [BITS_DATA-1:0] mem_wdat_q,  mem_wdat_d;
  logic                 mem_write_q, mem_write_d;
  logic [BITS_DATA-1:0] rdata_q,     rdata_d;
  logic [2:0]           rvalid_q,    rvalid_d;

  logic                 rd_fire;

  // Port 0 always wins; a 1/2 tie goes to the port that was not served last.
  // rr_last only ever holds PORT1 or PORT2.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    p2_gnt = 1'b0;
    win    = PORT0;
    accept = 1'b0;
    if (reset_n) begin
      if (p0_req) begin
        p0_gnt = 1'b1;
        win    = PORT0;
        accept = 1'b1;
      end else if (p1_req && (!p2_req || rr_last_q != PORT1)) begin
        p1_gnt = 1'b1;
        win    = PORT1;
        accept = 1'b1;
      end else if (p2_req) begin
        p2_gnt = 1'b1;
        win    = PORT2;
        accept = 1'b1;
      end
    end
  end

  always_comb begin
    win_we    = p0_we;
    win_addr  = p0_addr;
    win_wdata = p0_wdata;
    case (win)
      PORT1: begin
        win_we    = p1_we;
        win_addr  = p1_addr;
        win_wdata = p1_wdata;
      end
      PORT2: begin
        win_we    = p2_we;
        win_addr  = p2_addr;
        win_wdata = p2_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    rr_last_d   = rr_last_q;
    ex_valid_d  = accept;
    ex_port_d   = ex_port_q;
    mem_addr_d  = mem_addr_q;
    mem_wdat_d  = mem_wdat_q;
    mem_write_d = 1'b0;
    rdata_d     = rdata_q;
    rvalid_d    = '0;

    if (accept) begin
      ex_port_d   = win;
      mem_addr_d  = win_addr;
      mem_wdat_d  = win_wdata;
      mem_write_d = win_we;
      if (win != PORT0) rr_last_d = win;
    end

    // Read return: memory was addressed during the execute cycle.
    rd_fire = ex_valid_q && !mem_write_q;
    if (rd_fire) begin
      rdata_d = mem_data_out;
      case (ex_port_q)
        PORT0:   rvalid_d[0] = 1'b1;
        PORT1:   rvalid_d[1] = 1'b1;
        PORT2:   rvalid_d[2] = 1'b1;
        default: ;
      endcase
    end
  end

  // Asynchronous reset clears mem_write at once, aborting a write that has
  // not yet reached its falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_last_q   <= PORT2;
      ex_valid_q  <= 1'b0;
      ex_port_q   <= PORT0;
      mem_addr_q  <= '0;
      mem_wdat_q  <= '0;
      mem_write_q <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= '0;
    end else begin
      rr_last_q   <= rr_last_d;
      ex_valid_q  <= ex_valid_d;
      ex_port_q   <= ex_port_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdat_q  <= mem_wdat_d;
      mem_write_q <= mem_write_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign mem_address = mem_addr_q;
  assign mem_data_in = mem_wdat_q;
  assign mem_write   = mem_write_q;
  assign rdata       = rdata_q;
  assign p0_rvalid   = rvalid_q[0];
  assign p1_rvalid   = rvalid_q[1];
  assign p2_rvalid   = rvalid_q[2];

endmodule
